// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for memory_arbiter and its port-select helper.
// Holds the FSM state enum, port ids, write-section bit positions and the default memory size.
package memory_arbiter_pkg;

  localparam int unsigned DEFAULT_MEMORY_SIZE = 32'h1000;

  localparam int SEC_BYTE0 = 0;
  localparam int SEC_BYTE1 = 1;
  localparam int SEC_UPPER = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESPOND
  } state_e;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_e;

  // The upper section covers bytes 2 and 3 together (halfword/word stores).
  function automatic logic [3:0] sections_to_strobes(input logic [2:0] sections);
    return {sections[SEC_UPPER], sections[SEC_UPPER], sections[SEC_BYTE1], sections[SEC_BYTE0]};
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// arbiter_select: combinational choice between the fetch and data requesters.
// ARBITER_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise data always wins.
module arbiter_select
  import memory_arbiter_pkg::*;
(
  input  logic  fetch_request_i,
  input  logic  data_request_i,
`ifdef ARBITER_ROUND_ROBIN_EN
  input  port_e last_grant_i,
`endif
  output logic  grant_valid_o,
  output port_e grant_port_o
);

  always_comb begin
    grant_valid_o = fetch_request_i | data_request_i;
    grant_port_o  = PORT_DATA;
`ifdef ARBITER_ROUND_ROBIN_EN
    if (fetch_request_i && data_request_i) begin
      grant_port_o = (last_grant_i == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    end else if (fetch_request_i) begin
      grant_port_o = PORT_FETCH;
    end
`else
    if (fetch_request_i && !data_request_i) begin
      grant_port_o = PORT_FETCH;
    end
`endif
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port word memory between instruction fetch and load/store.
// Define ARBITER_ROUND_ROBIN_EN for round-robin tie breaking instead of data-over-fetch priority.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = DEFAULT_MEMORY_SIZE
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              fetch_request,
  input  logic [31:0]                       fetch_address,
  output logic                              fetch_ready,
  output logic                              fetch_valid,
  output logic [31:0]                       fetch_data,
  output logic                              fetch_fault,
  input  logic                              data_request,
  input  logic [31:0]                       data_address,
  input  logic [2:0]                        data_write_sections,
  input  logic [31:0]                       data_write_value,
  output logic                              data_ready,
  output logic                              data_valid,
  output logic [31:0]                       data_read_value,
  output logic                              data_fault,
  output logic [$clog2(MEMORY_SIZE)-3:0]    mem_address,
  output logic [3:0]                        mem_write_enable,
  output logic [31:0]                       mem_write_data,
  input  logic [31:0]                       mem_read_data
);

  localparam int AW = $clog2(MEMORY_SIZE) - 2;

  state_e        state_q;
  port_e         port_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          fault_q;

  logic          grant_valid;
  port_e         grant_port;
  logic          accept;
  logic [31:0]   sel_addr;
  logic [3:0]    sel_we;
  logic          sel_fault;

`ifdef ARBITER_ROUND_ROBIN_EN
  port_e last_grant_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT_DATA;
    end else if (accept) begin
      last_grant_q <= grant_port;
    end
  end
`endif

  arbiter_select u_select (
    .fetch_request_i (fetch_request),
    .data_request_i  (data_request),
`ifdef ARBITER_ROUND_ROBIN_EN
    .last_grant_i    (last_grant_q),
`endif
    .grant_valid_o   (grant_valid),
    .grant_port_o    (grant_port)
  );

  always_comb begin
    sel_addr  = (grant_port == PORT_DATA) ? data_address : fetch_address;
    sel_we    = (grant_port == PORT_DATA) ? sections_to_strobes(data_write_sections) : 4'b0000;
    sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEMORY_SIZE);
    accept    = (state_q == S_IDLE) && grant_valid;
  end

  // A faulted access skips ACCESS entirely, so its strobes never reach the memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      port_q  <= PORT_FETCH;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            port_q  <= grant_port;
            addr_q  <= sel_addr[AW+1:2];
            we_q    <= sel_fault ? 4'b0000 : sel_we;
            wdata_q <= (grant_port == PORT_DATA && !sel_fault) ? data_write_value : '0;
            rdata_q <= '0;
            fault_q <= sel_fault;
            state_q <= sel_fault ? S_RESPOND : S_ACCESS;
          end
        end
        S_ACCESS:  state_q <= (we_q != 4'b0000) ? S_RESPOND : S_CAPTURE;
        S_CAPTURE: begin
          rdata_q <= mem_read_data;
          state_q <= S_RESPOND;
        end
        S_RESPOND: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state alone, so an asynchronous reset removes them at once.
  always_comb begin
    fetch_ready      = accept && (grant_port == PORT_FETCH);
    data_ready       = accept && (grant_port == PORT_DATA);
    fetch_valid      = (state_q == S_RESPOND) && (port_q == PORT_FETCH);
    data_valid       = (state_q == S_RESPOND) && (port_q == PORT_DATA);
    fetch_data       = fetch_valid ? rdata_q : '0;
    fetch_fault      = fetch_valid && fault_q;
    data_read_value  = data_valid ? rdata_q : '0;
    data_fault       = data_valid && fault_q;
    mem_address      = addr_q;
    mem_write_enable = (state_q == S_ACCESS) ? we_q : 4'b0000;
    mem_write_data   = wdata_q;
  end

endmodule
